// File: rtl/uart_pkg.sv
// uart_pkg
// Shared defaults and helpers for the fractional baud generator.
//   DEF_*          default parameter values (50 MHz clock, 9600 baud, x16)
//   u64_t          64-bit unsigned type used for divisor arithmetic
//   baud_div_t     packed {integer, fraction} divisor at the default widths
//   calc_def_div   rounded divisor in 1/2^frac_w units
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
    localparam int unsigned DEF_BAUD_RATE = 9600;
    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam int unsigned DEF_DIV_W     = 16;
    localparam int unsigned DEF_FRAC_W    = 4;

    typedef longint unsigned u64_t;

    typedef struct packed {
        logic [DEF_DIV_W-1:0]  int_part;
        logic [DEF_FRAC_W-1:0] frac_part;
    } baud_div_t;

    // round(clk * 2^frac_w / (baud * os)), done as (2n + d) / 2d to stay integer
    function automatic u64_t calc_def_div(input int unsigned clk_freq,
                                          input int unsigned baud_rate,
                                          input int unsigned oversample,
                                          input int unsigned frac_w);
        u64_t num;
        u64_t den;
        num = u64_t'(clk_freq) << frac_w;
        den = u64_t'(baud_rate) * u64_t'(oversample);
        return (u64_t'(2) * num + den) / (u64_t'(2) * den);
    endfunction

endpackage

// File: rtl/baud_os_counter.sv
// baud_os_counter
// Modulo-OVERSAMPLE tick counter with wrap and mid-point pulses.
//   clk_i, rst_n_i  clock, async active-low reset
//   clr_i           hold the count at 0 (generator disabled)
//   sync_i          force count to 0; wins over a coincident tick
//   tick_i          base tick, advances the count
//   wrap_o          combinational: tick while count == OVERSAMPLE-1
//   mid_o           combinational: tick while count == OVERSAMPLE/2-1
module baud_os_counter #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic sync_i,
    input  logic tick_i,
    output logic wrap_o,
    output logic mid_o
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] MID_VAL  = CNT_W'(OVERSAMPLE / 2 - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Pulses are qualified by the pre-increment count; a sync suppresses them.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_o = 1'b0;
        mid_o  = 1'b0;
        if (clr_i || sync_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            wrap_o = (cnt_q == LAST_VAL);
            mid_o  = (cnt_q == MID_VAL);
            cnt_d  = (cnt_q == LAST_VAL) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac
// Fractional-N UART baud generator: a prescaler producing a base tick every
// div_int (+1 on accumulator carry) cycles, feeding RX and TX oversample
// counters.
//   clk_i, rst_n_i        clock, async active-low reset
//   en_i                  enable; low clears all counting state and outputs
//   div_int_i/div_frac_i  divisor captured into the shadow on div_load_i
//   rx_sync_i             restart RX bit phase
//   rx_tick_o             registered base tick (oversample rate)
//   rx_sample_o           RX mid-bit sample pulse, aligned with rx_tick_o
//   tx_tick_o             bit-rate pulse on TX counter wrap
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned DIV_W      = DEF_DIV_W,
    parameter int unsigned FRAC_W     = DEF_FRAC_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    input  logic              div_load_i,
    input  logic              rx_sync_i,
    output logic              rx_tick_o,
    output logic              rx_sample_o,
    output logic              tx_tick_o
);

    localparam u64_t DEF_DIV = calc_def_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE, FRAC_W);
    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_DIV >> FRAC_W);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV);

    logic [DIV_W:0]    cnt_q,       cnt_d;
    logic [FRAC_W-1:0] acc_q,       acc_d;
    logic [DIV_W-1:0]  act_int_q,   act_int_d;
    logic [FRAC_W-1:0] act_frac_q,  act_frac_d;
    logic [DIV_W-1:0]  shd_int_q,   shd_int_d;
    logic [FRAC_W-1:0] shd_frac_q,  shd_frac_d;
    logic              rx_tick_q,   rx_tick_d;
    logic              rx_sample_q, rx_sample_d;
    logic              tx_tick_q,   tx_tick_d;

    logic [FRAC_W:0]   frac_sum;
    logic [DIV_W-1:0]  eff_int;
    logic [DIV_W:0]    period_m1;
    logic              base_tick;
    logic              rx_mid;
    logic              tx_wrap;
    logic              rx_wrap_unused;
    logic              tx_mid_unused;

    // Period of the current base tick: the accumulator carry stretches it by
    // one cycle. A divisor below 2 is clamped so the counter always runs.
    always_comb begin
        frac_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
        eff_int   = (act_int_q < DIV_W'(2)) ? DIV_W'(2) : act_int_q;
        period_m1 = {1'b0, eff_int} + {{DIV_W{1'b0}}, frac_sum[FRAC_W]}
                  - {{DIV_W{1'b0}}, 1'b1};
        base_tick = en_i && (cnt_q == period_m1);
    end

    // Shadow is forwarded so a strobe coinciding with a transfer point is
    // not lost; the active divisor only changes at a period boundary or
    // while disabled, so no period is ever cut short.
    always_comb begin
        shd_int_d   = div_load_i ? div_int_i  : shd_int_q;
        shd_frac_d  = div_load_i ? div_frac_i : shd_frac_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        rx_tick_d   = 1'b0;
        rx_sample_d = 1'b0;
        tx_tick_d   = 1'b0;
        if (!en_i) begin
            cnt_d      = '0;
            acc_d      = '0;
            act_int_d  = shd_int_d;
            act_frac_d = shd_frac_d;
        end else if (base_tick) begin
            cnt_d       = '0;
            acc_d       = frac_sum[FRAC_W-1:0];
            act_int_d   = shd_int_d;
            act_frac_d  = shd_frac_d;
            rx_tick_d   = 1'b1;
            rx_sample_d = rx_mid;
            tx_tick_d   = tx_wrap;
        end else begin
            cnt_d = cnt_q + {{DIV_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            act_int_q   <= DEF_INT;
            act_frac_q  <= DEF_FRAC;
            shd_int_q   <= DEF_INT;
            shd_frac_q  <= DEF_FRAC;
            rx_tick_q   <= 1'b0;
            rx_sample_q <= 1'b0;
            tx_tick_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            shd_int_q   <= shd_int_d;
            shd_frac_q  <= shd_frac_d;
            rx_tick_q   <= rx_tick_d;
            rx_sample_q <= rx_sample_d;
            tx_tick_q   <= tx_tick_d;
        end
    end

    baud_os_counter #(.OVERSAMPLE(OVERSAMPLE)) u_rx_os (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (~en_i),
        .sync_i  (rx_sync_i),
        .tick_i  (base_tick),
        .wrap_o  (rx_wrap_unused),
        .mid_o   (rx_mid)
    );

    baud_os_counter #(.OVERSAMPLE(OVERSAMPLE)) u_tx_os (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (~en_i),
        .sync_i  (1'b0),
        .tick_i  (base_tick),
        .wrap_o  (tx_wrap),
        .mid_o   (tx_mid_unused)
    );

    assign rx_tick_o   = rx_tick_q;
    assign rx_sample_o = rx_sample_q;
    assign tx_tick_o   = tx_tick_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac
// Directed bench for baud_gen_frac at default parameters (50 MHz, 9600, x16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_baud_gen_frac;
    import uart_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        en_i;
    logic [15:0] div_int_i;
    logic [3:0]  div_frac_i;
    logic        div_load_i;
    logic        rx_sync_i;
    logic        rx_tick_o;
    logic        rx_sample_o;
    logic        tx_tick_o;

    int   assertCount = 0;
    int   failCount   = 0;
    logic lastTx;
    logic lastSample;

    baud_gen_frac dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .div_int_i   (div_int_i),
        .div_frac_i  (div_frac_i),
        .div_load_i  (div_load_i),
        .rx_sync_i   (rx_sync_i),
        .rx_tick_o   (rx_tick_o),
        .rx_sample_o (rx_sample_o),
        .tx_tick_o   (tx_tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic load,
                                 input logic [15:0] dInt, input logic [3:0] dFrac,
                                 input logic sync);
        en_i       = en;
        div_load_i = load;
        div_int_i  = dInt;
        div_frac_i = dFrac;
        rx_sync_i  = sync;
    endtask

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulseLoad(input logic [15:0] dInt, input logic [3:0] dFrac);
        applyStimulus(en_i, 1'b1, dInt, dFrac, 1'b0);
        stepCycle();
        applyStimulus(en_i, 1'b0, dInt, dFrac, 1'b0);
    endtask

    task automatic pulseSync();
        applyStimulus(en_i, 1'b0, div_int_i, div_frac_i, 1'b1);
        stepCycle();
        applyStimulus(en_i, 1'b0, div_int_i, div_frac_i, 1'b0);
    endtask

    // Cycles until rx_tick_o is seen, or -1 if the budget runs out
    task automatic waitTick(input int maxCycles, output int cycles);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        cycles = -1;
        while (!seen && n < maxCycles) begin
            stepCycle();
            n++;
            if (rx_tick_o === 1'b1) begin
                seen       = 1'b1;
                cycles     = n;
                lastTx     = tx_tick_o;
                lastSample = rx_sample_o;
            end
        end
    endtask

    task automatic waitTx(input int maxCycles, output int cycles);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        cycles = -1;
        while (!seen && n < maxCycles) begin
            stepCycle();
            n++;
            if (tx_tick_o === 1'b1) begin
                seen   = 1'b1;
                cycles = n;
            end
        end
    endtask

    initial begin
        int        cyc;
        int        cyc2;
        int        sumCyc;
        int        txCount;
        int        txIdx;
        int        sampleCount;
        int        sampleIdx;
        baud_div_t d;

        // Reset state with the generator disabled
        rst_n_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0, 1'b0);
        repeat (3) stepCycle();
        checkOutput("reset_rx_tick", {31'd0, rx_tick_o}, 32'd0);
        checkOutput("reset_tx_tick", {31'd0, tx_tick_o}, 32'd0);
        checkOutput("reset_rx_sample", {31'd0, rx_sample_o}, 32'd0);
        rst_n_i = 1'b1;
        repeat (3) stepCycle();
        checkOutput("disabled_rx_tick", {31'd0, rx_tick_o}, 32'd0);

        // Default divisor 325 + 8/16: periods 325/326, 16 ticks = 5208
        $display("[TB] default divisor run");
        applyStimulus(1'b1, 1'b0, 16'd0, 4'd0, 1'b0);
        sumCyc = 0; txCount = 0; txIdx = 0; sampleCount = 0; sampleIdx = 0;
        for (int k = 1; k <= 16; k++) begin
            waitTick(400, cyc);
            if (k == 1) checkOutput("default_first_period", cyc, 32'd325);
            if (k == 2) checkOutput("default_second_period", cyc, 32'd326);
            sumCyc += cyc;
            if (lastTx === 1'b1) begin txCount++; txIdx = k; end
            if (lastSample === 1'b1) begin sampleCount++; sampleIdx = k; end
        end
        checkOutput("default_16_ticks", sumCyc, 32'd5208);
        checkOutput("default_tx_count", txCount, 32'd1);
        checkOutput("default_tx_index", txIdx, 32'd16);
        checkOutput("default_sample_count", sampleCount, 32'd1);
        checkOutput("default_sample_index", sampleIdx, 32'd8);

        // Divisor 27 + 2/16, loaded just after a tick: old 325 period finishes
        $display("[TB] divisor 27+2/16");
        d.int_part  = 16'd27;
        d.frac_part = 4'd2;
        pulseLoad(d.int_part, d.frac_part);
        waitTick(400, cyc);
        checkOutput("load27_old_period", cyc, 32'd324);
        waitTick(100, cyc);
        checkOutput("load27_first_period", cyc, 32'd27);
        waitTx(600, cyc);
        checkOutput("load27_to_tx", cyc, 32'd380);
        waitTx(600, cyc);
        checkOutput("load27_tx_period", cyc, 32'd434);
        checkOutput("tx_rx_coincide", {31'd0, rx_tick_o}, 32'd1);

        // RX resync mid-bit: sample on 8th following tick, TX unaffected
        $display("[TB] rx resync");
        for (int k = 1; k <= 5; k++) waitTick(100, cyc);
        repeat (3) stepCycle();
        pulseSync();
        txIdx = 0;
        sampleIdx = 0;
        for (int j = 1; j <= 12; j++) begin
            waitTick(100, cyc);
            if (lastSample === 1'b1 && sampleIdx == 0) sampleIdx = j;
            if (lastTx === 1'b1 && txIdx == 0) txIdx = j;
        end
        checkOutput("sync_sample_index", sampleIdx, 32'd8);
        checkOutput("sync_tx_index", txIdx, 32'd11);

        // Divisor 100, then reload mid-period (50 then 10, last wins)
        $display("[TB] mid-period reload");
        pulseLoad(16'd100, 4'd0);
        waitTick(200, cyc);
        waitTick(200, cyc);
        checkOutput("div100_period", cyc, 32'd100);
        repeat (40) stepCycle();
        pulseLoad(16'd50, 4'd0);
        pulseLoad(16'd10, 4'd0);
        waitTick(200, cyc2);
        checkOutput("period_spanning_load", cyc2 + 42, 32'd100);
        waitTick(200, cyc);
        checkOutput("last_load_wins", cyc, 32'd10);

        // div_int 0 clamps to 2
        $display("[TB] divisor 0 clamp and enable control");
        pulseLoad(16'd0, 4'd0);
        waitTick(100, cyc);
        checkOutput("div10_before_div0", cyc, 32'd9);
        waitTick(100, cyc);
        checkOutput("div0_period_a", cyc, 32'd2);
        waitTick(100, cyc);
        checkOutput("div0_period_b", cyc, 32'd2);

        // Disable one cycle before a tick is due: nothing is emitted
        stepCycle();
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0, 1'b0);
        stepCycle();
        checkOutput("disable_rx_tick", {31'd0, rx_tick_o}, 32'd0);
        checkOutput("disable_tx_tick", {31'd0, tx_tick_o}, 32'd0);
        checkOutput("disable_rx_sample", {31'd0, rx_sample_o}, 32'd0);

        // Load while disabled takes effect at once; re-enable restarts cleanly
        pulseLoad(16'd5, 4'd0);
        repeat (2) stepCycle();
        applyStimulus(1'b1, 1'b0, 16'd5, 4'd0, 1'b0);
        waitTick(50, cyc);
        checkOutput("reenable_first_tick", cyc, 32'd5);
        waitTx(200, cyc);
        checkOutput("reenable_tx", cyc, 32'd75);
        checkOutput("reenable_tx_rx_coincide", {31'd0, rx_tick_o}, 32'd1);

        // Asynchronous reset while both ticks are high
        $display("[TB] async reset");
        rst_n_i = 1'b0;
        #1;
        checkOutput("async_rst_rx_tick", {31'd0, rx_tick_o}, 32'd0);
        checkOutput("async_rst_tx_tick", {31'd0, tx_tick_o}, 32'd0);
        repeat (2) stepCycle();
        rst_n_i = 1'b1;
        stepCycle();
        checkOutput("release_cycle_rx_tick", {31'd0, rx_tick_o}, 32'd0);
        waitTick(400, cyc);
        checkOutput("post_reset_first_period", cyc, 32'd324);
        waitTick(400, cyc);
        checkOutput("post_reset_second_period", cyc, 32'd326);
        waitTx(6000, cyc);
        checkOutput("post_reset_to_tx", cyc, 32'd4557);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
